uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for the FPGA I/O path: samples the board's asynchronous RX pin, decodes 8N1 frames, and delivers bytes over a valid/ready stream through a small receive FIFO. Sits between the board-level RX pin and the core's UART peripheral, as the counterpart of the core's TX serializer. Reports framing errors and overruns as single-cycle pulses for status counting.

---
 rtl/uart_receiver_pkg.sv | 15 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_receiver.sv | 103 ++++++++++
 tb/tb_uart_receiver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
package uart_receiver_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int FRAME_BITS           = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is reset too so the head output reads zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop rx synchronizer, mid-bit sampling FSM and a
// receive FIFO presented as a valid/ready stream.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

  rx_state_e             state;
  logic                  rx_meta, rx_sync;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  push_req, pop, fifo_full, fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Push happens on the stop-sample edge itself so valid rises one cycle later.
  assign push_req = (state == S_STOP) && (timer == FULL_T) && rx_sync;
  assign pop      = valid && ready;
  assign valid    = !fifo_empty;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= push_req && fifo_full && !pop;
      case (state)
        S_IDLE: if (!rx_sync) begin
          state <= S_START;
          timer <= '0;
        end
        S_START: if (timer == HALF_T) begin
          timer   <= '0;
          bit_idx <= '0;
          state   <= rx_sync ? S_IDLE : S_DATA;
        end else timer <= timer + 1'b1;
        S_DATA: if (timer == FULL_T) begin
          timer <= '0;
          shreg <= {rx_sync, shreg[FRAME_BITS-1:1]};
          if (bit_idx == BW'(FRAME_BITS - 1)) state <= S_STOP;
          else bit_idx <= bit_idx + 1'b1;
        end else timer <= timer + 1'b1;
        // Leaving at mid-stop gives half a bit of slack for a back-to-back start.
        S_STOP: if (timer == FULL_T) begin
          timer <= '0;
          if (rx_sync) state <= S_IDLE;
          else begin
            framing_err <= 1'b1;
            state       <= S_BREAK;
          end
        end else timer <= timer + 1'b1;
        S_BREAK: if (rx_sync) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver against a queue-based model of delivered bytes.
module tb_uart_receiver;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, framing_err, overrun, busy;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int         n_chk = 0, n_pass = 0;
  int         n_pop = 0, fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  int         push_k = 155, cnt, p0;
  logic       fe_prev = 1'b0, ov_prev = 1'b0, done;
  logic [7:0] exp_q[$];
  logic [7:0] b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: a good frame lands in the FIFO unless DEPTH bytes are already waiting.
  task automatic expect_byte(input logic [7:0] v);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else exp_ov++;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) tick();
    end
    rx = stop_ok;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (valid && ready) begin
          n_pop++;
          chk("pop_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("data", data, exp_q.pop_front());
        end
        if (framing_err) begin fe_cnt++; chk("fe_width", fe_prev, 0); end
        if (overrun)     begin ov_cnt++; chk("ov_width", ov_prev, 0); end
        fe_prev = framing_err;
        ov_prev = overrun;
      end
    join_none

    repeat (3) tick();
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fe", framing_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single frame, latency from start edge to valid
    ready = 1'b1;
    expect_byte(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        cnt = 0;
        do begin @(negedge clock); cnt++; end while (!valid && cnt < 400);
        push_k = cnt - 1;
        chk("a5_latency_ok", (push_k >= 150 && push_k <= 166), 1);
        @(negedge clock);
        chk("a5_valid_1cyc", valid, 0);
      end
    join
    repeat (4) tick();
    chk("a5_delivered", exp_q.size(), 0);
    chk("a5_fe", fe_cnt, exp_fe);
    chk("a5_ov", ov_cnt, exp_ov);

    // One-cycle glitch must be rejected
    p0 = n_pop;
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (CPB/2 + 3) tick();
    chk("glitch_busy", busy, 0);
    repeat (CPB) tick();
    chk("glitch_pop", n_pop, p0);
    chk("glitch_fe", fe_cnt, exp_fe);

    // Bad stop bit, line held low, then a good frame
    exp_fe++;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    rx = 1'b1;
    repeat (CPB) tick();
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (5) tick();
    chk("brk_fe", fe_cnt, exp_fe);
    chk("brk_55_delivered", exp_q.size(), 0);

    // Overrun with consumer stalled
    ready = 1'b0;
    p0 = n_pop;
    for (int v = 1; v <= 5; v++) begin
      expect_byte(8'(v));
      send_frame(8'(v), 1'b1);
    end
    repeat (4) tick();
    chk("ovr_pulse", ov_cnt, exp_ov);
    chk("ovr_valid", valid, 1);
    ready = 1'b1;
    drain("ovr_drain");
    chk("ovr_pops", n_pop - p0, 4);

    // Full FIFO, pop coincides with the stop-sample push
    ready = 1'b0;
    p0 = n_pop;
    for (int v = 1; v <= 4; v++) begin
      expect_byte(8'(v));
      send_frame(8'(v), 1'b1);
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (push_k - 1) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    join
    expect_byte(8'h05);
    repeat (4) tick();
    chk("same_cyc_ov", ov_cnt, exp_ov);
    ready = 1'b1;
    drain("same_cyc_drain");
    chk("same_cyc_pops", n_pop - p0, 5);

    // Reset in the middle of a frame
    p0 = n_pop;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (CPB * 4) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        tick();
        reset_n = 1'b1;
      end
    join
    repeat (CPB) tick();
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (5) tick();
    chk("midrst_81", exp_q.size(), 0);
    chk("midrst_pops", n_pop - p0, 1);

    // Random bytes, random gaps (including zero), random ready
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          b = 8'($urandom);
          expect_byte(b);
          send_frame(b, 1'b1);
          repeat ($urandom_range(0, 4)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    ready = 1'b1;
    drain("rand_drain");
    chk("rand_fe", fe_cnt, exp_fe);
    chk("rand_ov", ov_cnt, exp_ov);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
